// File: rtl/prioritet_dispatcher.sv
// Request dispatcher: sticky pending bits feed an 8-bit priority encoder,
// and the highest pending index is offered downstream over valid/ready.

module prioritet_decypher (
  input  logic [7:0] number,
  output logic [2:0] ub
);

  // Index of the highest set bit; all-zero input yields 0.
  always_comb begin
    ub = 3'd0;
    casez (number)
      8'b1???????: ub = 3'd7;
      8'b01??????: ub = 3'd6;
      8'b001?????: ub = 3'd5;
      8'b0001????: ub = 3'd4;
      8'b00001???: ub = 3'd3;
      8'b000001??: ub = 3'd2;
      8'b0000001?: ub = 3'd1;
      8'b00000001: ub = 3'd0;
      default:     ub = 3'd0;
    endcase
  end

endmodule

module prioritet_dispatcher #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          flush,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [IW-1:0] out_idx,
  output logic [IW:0]   pend_cnt,
  output logic          dup
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t        state_q;
  logic [N-1:0]  pending_q;
  logic [N-1:0]  pending_d;
  logic          dup_q;
  logic          dup_d;
  logic [IW:0]   pend_cnt_q;
  logic [IW:0]   pend_cnt_d;
  logic          out_valid_q;
  logic [IW-1:0] out_idx_q;
  logic [IW-1:0] enc_s;
  logic          accept_s;
  logic [N-1:0]  acc_mask_s;

  function automatic logic [IW:0] popcount(input logic [N-1:0] v);
    logic [IW:0] cnt;
    cnt = {(IW+1){1'b0}};
    for (int i = 0; i < N; i++) begin
      cnt = cnt + {{IW{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  prioritet_decypher u_enc (
    .number (pending_q),
    .ub     (enc_s)
  );

  // Acceptance mask, next pending vector, sticky duplicate flag and count.
  always_comb begin
    accept_s   = out_valid_q & out_ready;
    acc_mask_s = {N{1'b0}};
    pending_d  = pending_q;
    dup_d      = dup_q;
    if (accept_s) begin
      acc_mask_s = {{(N-1){1'b0}}, 1'b1} << out_idx_q;
    end else begin
      acc_mask_s = {N{1'b0}};
    end
    // A re-request of the bit being accepted survives as a fresh request.
    if (flush) begin
      pending_d = {N{1'b0}};
      dup_d     = 1'b0;
    end else begin
      pending_d = (pending_q & ~acc_mask_s) | req;
      dup_d     = dup_q | (|(req & pending_q & ~acc_mask_s));
    end
    pend_cnt_d = popcount(pending_d);
  end

  // Pending bits, duplicate flag and population count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= {N{1'b0}};
      dup_q      <= 1'b0;
      pend_cnt_q <= {(IW+1){1'b0}};
    end else begin
      pending_q  <= pending_d;
      dup_q      <= dup_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  // Offer FSM; out_idx is frozen while an offer is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_idx_q   <= {IW{1'b0}};
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|pending_q) begin
            out_idx_q   <= enc_s;
            out_valid_q <= 1'b1;
            state_q     <= OFFER;
          end else begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        OFFER: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            out_valid_q <= 1'b1;
            state_q     <= OFFER;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pend_cnt  = pend_cnt_q;
  assign dup       = dup_q;

endmodule

// File: tb/tb_prioritet_dispatcher.sv
// Directed, table-driven bench for prioritet_dispatcher plus hand-written
// sequences for asynchronous reset in the middle of an offer.

module tb_prioritet_dispatcher;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [3:0] pend_cnt;
  logic       dup;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] req;
    logic       flush;
    logic       rdy;
    logic       v;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic       dup;
  } vec_t;

  vec_t vq[$];

  prioritet_dispatcher dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pend_cnt  (pend_cnt),
    .dup       (dup)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] r, input logic f, input logic rd,
                     input logic v, input logic [2:0] i, input logic [3:0] c, input logic d);
    vec_t e;
    e.req = r; e.flush = f; e.rdy = rd; e.v = v; e.idx = i; e.cnt = c; e.dup = d;
    vq.push_back(e);
  endtask

  initial begin
    // Test 1: grants 6,3,2 two cycles apart
    add(8'h4C, 1'b0, 1'b1, 1'b0, 3'd0, 4'd3, 1'b0);
    add(8'h00, 1'b0, 1'b1, 1'b1, 3'd6, 4'd3, 1'b0);
    add(8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 4'd2, 1'b0);
    add(8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 4'd2, 1'b0);
    add(8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 4'd1, 1'b0);
    add(8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 4'd1, 1'b0);
    add(8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
    add(8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
    // Test 2: stalled offer of 3 survives a higher-priority arrival
    add(8'h0B, 1'b0, 1'b0, 1'b0, 3'd0, 4'd3, 1'b0);
    add(8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 4'd3, 1'b0);
    add(8'h80, 1'b0, 1'b0, 1'b1, 3'd3, 4'd4, 1'b0);
    add(8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 4'd4, 1'b0);
    add(8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 4'd4, 1'b0);
    add(8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 4'd4, 1'b0);
    add(8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 4'd3, 1'b0);
    add(8'h00, 1'b0, 1'b1, 1'b1, 3'd7, 4'd3, 1'b0);
    add(8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 4'd2, 1'b0);
    add(8'h00, 1'b0, 1'b1, 1'b1, 3'd1, 4'd2, 1'b0);
    add(8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 4'd1, 1'b0);
    add(8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 4'd1, 1'b0);
    add(8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
    // Test 3: single grant of index 0, then nothing from an empty encoder
    add(8'h01, 1'b0, 1'b1, 1'b0, 3'd0, 4'd1, 1'b0);
    add(8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 4'd1, 1'b0);
    add(8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
    add(8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
    add(8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
    // Test 4: re-request in accept cycle is not a duplicate; a real one is
    add(8'h20, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1, 1'b0);
    add(8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 4'd1, 1'b0);
    add(8'h20, 1'b0, 1'b1, 1'b0, 3'd0, 4'd1, 1'b0);
    add(8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 4'd1, 1'b0);
    add(8'h20, 1'b0, 1'b0, 1'b1, 3'd5, 4'd1, 1'b1);
    add(8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 4'd1, 1'b1);
    add(8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    add(8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    // Test 5: flush with everything pending, concurrent req/handshake dropped
    add(8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 4'd8, 1'b0);
    add(8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 4'd8, 1'b0);
    add(8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
    add(8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    add(8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);

    // Reset state
    #12;
    check("reset_valid", -1, {7'd0, out_valid}, 8'h00);
    check("reset_idx",   -1, {5'd0, out_idx},   8'h00);
    check("reset_cnt",   -1, {4'd0, pend_cnt},  8'h00);
    check("reset_dup",   -1, {7'd0, dup},       8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vq[k]) begin
      req       = vq[k].req;
      flush     = vq[k].flush;
      out_ready = vq[k].rdy;
      @(posedge clk);
      #1;
      check("valid", k, {7'd0, out_valid}, {7'd0, vq[k].v});
      check("cnt",   k, {4'd0, pend_cnt},  {4'd0, vq[k].cnt});
      check("dup",   k, {7'd0, dup},       {7'd0, vq[k].dup});
      if (vq[k].v) begin
        check("idx", k, {5'd0, out_idx}, {5'd0, vq[k].idx});
      end
    end

    // Test 6: async reset mid-offer with dup set
    req = 8'hFF; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    req = 8'h80;
    @(posedge clk); #1;
    req = 8'h00;
    check("pre_rst_valid", 100, {7'd0, out_valid}, 8'h01);
    check("pre_rst_idx",   100, {5'd0, out_idx},   8'h07);
    check("pre_rst_dup",   100, {7'd0, dup},       8'h01);
    #3;
    rst = 1'b1;
    #1;
    check("async_valid", 101, {7'd0, out_valid}, 8'h00);
    check("async_idx",   101, {5'd0, out_idx},   8'h00);
    check("async_cnt",   101, {4'd0, pend_cnt},  8'h00);
    check("async_dup",   101, {7'd0, dup},       8'h00);
    @(negedge clk);
    rst = 1'b0;
    req = 8'h10; out_ready = 1'b0;
    @(posedge clk); #1;
    req = 8'h00;
    check("post_rst_valid", 102, {7'd0, out_valid}, 8'h00);
    check("post_rst_cnt",   102, {4'd0, pend_cnt},  8'h01);
    @(posedge clk); #1;
    check("post_rst_valid", 103, {7'd0, out_valid}, 8'h01);
    check("post_rst_idx",   103, {5'd0, out_idx},   8'h04);
    check("post_rst_dup",   103, {7'd0, dup},       8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prioritet_dispatcher.md
Name: prioritet_dispatcher

Overview:
Sequential request dispatcher built around the existing 8-bit priority encoder prioritet_decypher (number[7:0] -> ub[2:0], index of highest set bit). It captures one-cycle request pulses into sticky pending bits and feeds the pending vector to an internal prioritet_decypher instance. It then issues the highest pending index downstream over a valid/ready handshake, and clears each bit when its index is accepted. It sits between the raw request sources and the consumer of encoded indices.

Parameters:
N, 8, request width; fixed at 8 to match prioritet_decypher, and must not be overridden.
IW, 3, index width, log2(N).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-high.
req  input  N  request pulses; bit i set means request i.
flush  input  1  synchronous clear of all pending bits and the sticky flag.
out_ready  input  1  consumer accepts out_idx this cycle.
out_valid  output  1  out_idx holds a valid pending index.
out_idx  output  IW  granted index, registered.
pend_cnt  output  IW+1  population count of the pending register, registered.
dup  output  1  sticky flag: a request arrived for an index already pending.

Behaviour:
- Reset (async assert): pending=0, state=IDLE, out_valid=0, out_idx=0, pend_cnt=0, dup=0. Release is synchronous to clk.
- Pending register update each edge: pending <= (pending & ~acc_mask) | req.
  - acc_mask = one-hot(out_idx) when out_valid & out_ready; otherwise 0.
  - If req sets the same bit that is being accepted, the bit stays set as a new request.
- dup is set when (req & pending & ~acc_mask) != 0. It is cleared only by rst or flush.
- pend_cnt equals the popcount of the pending register value; it updates on the same edge as pending.
- The prioritet_decypher instance is driven by the pending register; its ub output is called enc.
- FSM has two states: IDLE and OFFER.
  - IDLE with pending != 0: next edge loads out_idx <= enc, sets out_valid=1, goes to OFFER.
  - IDLE with pending == 0: stays in IDLE with out_valid=0. The encoder output for all-zero input is ignored.
  - OFFER: out_idx and out_valid are held stable until out_ready=1. Higher-priority requests arriving meanwhile do not change out_idx.
  - OFFER with out_ready=1: at the edge the bit is cleared, out_valid goes to 0 and the FSM returns to IDLE.
- Latency: a req pulse at edge E sets pending at E and out_valid at E+1. Throughput is one grant per 2 cycles at most.
- flush (sync) clears pending and dup, forces IDLE and out_valid=0. Any concurrent req or handshake in that cycle is discarded. flush has priority over everything except rst.
- rst asserted mid-OFFER drops the offer immediately, with no acceptance recorded.
- out_ready while out_valid=0 is ignored.

Test Plan:
1. req=8'b01001100 for 1 cycle, out_ready=1 held -> grants in order 6, 3, 2, spaced 2 cycles apart; pend_cnt 3->2->1->0; dup=0.
2. req=8'b00001011, out_ready=0 for 5 cycles -> out_valid=1 and out_idx=3 held stable. Pulse req bit 7 meanwhile -> out_idx stays 3. After out_ready -> next grants are 7, 1, 0.
3. req=8'b00000001 with out_ready=1 -> single grant idx 0, then out_valid=0 and pending=0. The all-zero encoder output never produces a grant.
4. Offer idx 5 while req bit 5 pulses in the accept cycle -> bit 5 stays pending and idx 5 is granted again; dup=0. req bit 5 pulsed while 5 is pending and not being accepted -> dup=1 until flush.
5. pending=8'hFF in OFFER, assert flush -> next cycle out_valid=0, pend_cnt=0, dup=0, IDLE.
6. Assert rst asynchronously mid-OFFER, between clock edges -> all outputs 0 immediately. After release, a new req=8'b00010000 -> out_idx=4 one cycle later.
